// File: rtl/fifo_byte_packer.sv
// Byte FIFO read-side packer: pops bytes, packs LANES of them per word, presents
// words on a valid/ready master port. Optional partial-word flush: PACKER_FLUSH_EN.
module fifo_byte_packer #(
    parameter int D_WIDTH      = 8,
    parameter int LANES        = 2,
    parameter int FLUSH_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fifo_empty,
    output logic                       fifo_pop,
    input  logic [D_WIDTH-1:0]         fifo_rdata,
    output logic                       m_valid,
    output logic [D_WIDTH*LANES-1:0]   m_data,
    output logic [LANES-1:0]           m_keep,
    input  logic                       m_ready
);

    localparam int CNT_W = $clog2(LANES + 1);

    if (LANES < 2 || FLUSH_CYCLES < 1) begin : g_param_check
        $error("fifo_byte_packer: LANES must be >= 2 and FLUSH_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [D_WIDTH-1:0]     r_acc [LANES];
    logic [CNT_W-1:0]       r_acc_cnt;
    logic                   r_rd_pending;

    logic                   w_out_free;
    logic                   w_full;
    logic                   w_xfer;
    logic [CNT_W-1:0]       w_base_cnt;
    logic [CNT_W-1:0]       w_acc_cnt_nxt;
    logic                   w_pop_ok;
    logic                   w_m_valid_nxt;
    logic [D_WIDTH*LANES-1:0] w_out_data;
    logic [LANES-1:0]       w_out_keep;

`ifdef PACKER_FLUSH_EN
    localparam int IDLE_W = $clog2(FLUSH_CYCLES + 1);
    logic [IDLE_W-1:0]      r_idle_cnt;
    logic                   w_idle_run;
    logic                   w_flush_go;
`endif

    always_comb begin
        w_out_free = !m_valid || m_ready;
        w_full     = (r_acc_cnt == CNT_W'(LANES));
`ifdef PACKER_FLUSH_EN
        w_xfer = w_out_free && (w_full || (r_state == ST_FLUSH && r_acc_cnt != '0));
`else
        w_xfer = w_out_free && w_full;
`endif
        // A slot freed by this cycle's transfer may be refilled immediately, so no bubble.
        w_base_cnt    = w_xfer ? '0 : r_acc_cnt;
        w_pop_ok      = ({1'b0, w_base_cnt} + (CNT_W+1)'(r_rd_pending)) < (CNT_W+1)'(LANES);
        w_acc_cnt_nxt = w_base_cnt + CNT_W'(r_rd_pending);
        w_m_valid_nxt = w_xfer || (m_valid && !m_ready);
        fifo_pop      = rst_n && !fifo_empty && w_pop_ok;
`ifdef PACKER_FLUSH_EN
        if (r_state == ST_FLUSH) begin
            fifo_pop = 1'b0;
        end
`endif
    end

    always_comb begin
        w_out_data = '0;
        w_out_keep = '0;
        for (int i = 0; i < LANES; i++) begin
`ifdef PACKER_FLUSH_EN
            if (CNT_W'(i) < r_acc_cnt) begin
                w_out_data[i*D_WIDTH +: D_WIDTH] = r_acc[i];
                w_out_keep[i]                    = 1'b1;
            end
`else
            w_out_data[i*D_WIDTH +: D_WIDTH] = r_acc[i];
            w_out_keep[i]                    = 1'b1;
`endif
        end
    end

`ifdef PACKER_FLUSH_EN
    always_comb begin
        w_idle_run = (r_state == ST_FILL) && (r_acc_cnt != '0) && !w_full
                     && !fifo_pop && !r_rd_pending;
        w_flush_go = w_idle_run && (r_idle_cnt == IDLE_W'(FLUSH_CYCLES));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= '0;
        end else if (!w_idle_run || w_flush_go) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FLUSH: begin
                if (w_xfer) begin
                    w_state_nxt = ST_FILL;
                end
            end
            default: begin
                if (w_acc_cnt_nxt == CNT_W'(LANES) && w_m_valid_nxt) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = ST_FILL;
                end
`ifdef PACKER_FLUSH_EN
                if (w_flush_go) begin
                    w_state_nxt = ST_FLUSH;
                end
`endif
            end
        endcase
    end

    // NOTE: accumulator lanes carry no reset; r_acc_cnt alone says which lanes are live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (r_rd_pending && w_base_cnt == CNT_W'(i)) begin
                r_acc[i] <= fifo_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_FILL;
            r_acc_cnt    <= '0;
            r_rd_pending <= 1'b0;
            m_valid      <= 1'b0;
            m_data       <= '0;
            m_keep       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_acc_cnt    <= w_acc_cnt_nxt;
            r_rd_pending <= fifo_pop;
            m_valid      <= w_m_valid_nxt;
            if (w_xfer) begin
                m_data <= w_out_data;
                m_keep <= w_out_keep;
            end
        end
    end

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Scoreboard bench for fifo_byte_packer: a byte-FIFO model feeds the DUT, directed
// stimulus queues expected words, and a negedge monitor compares every presented word.
module tb_fifo_byte_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fifo_empty = 1'b0;
    logic        fifo_pop;
    logic [7:0]  fifo_rdata = 8'h00;
    logic        m_valid;
    logic [15:0] m_data;
    logic [1:0]  m_keep;
    logic        m_ready = 1'b0;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  keep;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] src_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         pop_cnt = 0;
    bit         force_ne = 1'b1;
    bit         gap_mode = 1'b0;
    bit         gap_phase = 1'b0;

    always #5 clk = ~clk;

    fifo_byte_packer #(.D_WIDTH(8), .LANES(2), .FLUSH_CYCLES(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .fifo_rdata (fifo_rdata),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_keep     (m_keep),
        .m_ready    (m_ready)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // FIFO model: registered read data, one byte per pop.
    always @(posedge clk) begin
        if (fifo_pop) begin
            if (src_q.size() != 0) fifo_rdata <= src_q.pop_front();
            else                   fifo_rdata <= 8'hEE;
            pop_cnt <= pop_cnt + 1;
        end
    end

    always @(posedge clk) begin
        #3;
        gap_phase  = ~gap_phase;
        fifo_empty = force_ne ? 1'b0 : ((src_q.size() == 0) || (gap_mode && gap_phase));
    end

    // Monitor: every presented word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (fifo_pop) check("pop_while_empty", {31'd0, fifo_empty}, 32'd0);
        if (rst_n && m_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat_valid", {31'd0, m_valid}, 32'd0);
            end else begin
                check("m_data", {16'd0, m_data}, {16'd0, exp_q[0].data});
                check("m_keep", {30'd0, m_keep}, {30'd0, exp_q[0].keep});
                if (m_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_exp(input logic [15:0] d, input logic [1:0] k);
        beat_t b;
        b.data = d;
        b.keep = k;
        exp_q.push_back(b);
    endtask

    task automatic drain(input string name, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            step(1);
            k++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
        check({tag, "_m_data"},  {16'd0, m_data},  32'd0);
        check({tag, "_m_keep"},  {30'd0, m_keep},  32'd0);
    endtask

    initial begin
        int base;

        // 1. reset with a non-empty FIFO
        step(2);
        check("rst_fifo_pop", {31'd0, fifo_pop}, 32'd0);
        check_idle_outputs("rst");
        force_ne = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1);

        // 2. streaming with m_ready high
        base = pop_cnt;
        m_ready = 1'b1;
        src_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        push_exp(16'h2211, 2'b11);
        push_exp(16'h4433, 2'b11);
        drain("t2_drain", 40);
        check("t2_pops", pop_cnt - base, 4);

        // 3. backpressure: pops stop once acc and output register are both full
        base = pop_cnt;
        m_ready = 1'b0;
        src_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        push_exp(16'h0201, 2'b11);
        push_exp(16'h0403, 2'b11);
        push_exp(16'h0605, 2'b11);
        step(12);
        check("t3_pops_stalled", pop_cnt - base, 4);
        check("t3_fifo_left", src_q.size(), 2);
        check("t3_held_valid", {31'd0, m_valid}, 32'd1);
        check("t3_held_data", {16'd0, m_data}, 32'h0201);
        m_ready = 1'b1;
        drain("t3_drain", 40);
        check("t3_pops_total", pop_cnt - base, 6);

        // 4. FIFO empty flag toggling every cycle
        base = pop_cnt;
        gap_mode = 1'b1;
        src_q = '{8'hA1, 8'hB2};
        push_exp(16'hB2A1, 2'b11);
        drain("t4_drain", 40);
        check("t4_pops", pop_cnt - base, 2);
        gap_mode = 1'b0;

        // 5. odd byte count: partial word flushed only with the feature enabled
        base = pop_cnt;
        src_q = '{8'h11, 8'h22, 8'h33};
        push_exp(16'h2211, 2'b11);
`ifdef PACKER_FLUSH_EN
        push_exp(16'h0033, 2'b01);
        drain("t5_drain_flush", 80);
`else
        drain("t5_drain", 40);
        step(40);
        check("t5_no_third_beat", {31'd0, m_valid}, 32'd0);
`endif
        check("t5_pops", pop_cnt - base, 3);

        // 6. reset mid-word discards the partial accumulator
        do_reset();
        base = pop_cnt;
        src_q = '{8'h55};
        step(4);
        check("t6_popped_55", pop_cnt - base, 1);
        check("t6_no_word_yet", {31'd0, m_valid}, 32'd0);
        do_reset();
        check_idle_outputs("t6_rst");
        base = pop_cnt;
        src_q = '{8'h66, 8'h77};
        push_exp(16'h7766, 2'b11);
        drain("t6_drain", 40);
        check("t6_pops", pop_cnt - base, 2);

        step(5);
        check("final_scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
